nova_inter_buf: RTL
===================

Name: nova_inter_buf

Overview:
Parametrised successor to the switch-to-decoder interface wrapper. It puts an elastic FIFO on each side of the nova core: an input FIFO (switch → core) and an output FIFO (core → switch). It replaces "never retry" with real occupancy-based retry on outStop and honours downstream stop without losing decoder output. It sits between the rnet switch port and the nova core, and is reused for any core whose packet widths are given as parameters.

Parameters:
IN_W, 96, input packet width in bits (bitstream word plus two RAM data words)
OUT_W, 128, output packet width in bits
IN_DEPTH, 8, input FIFO entries, 2..64
OUT_DEPTH, 4, output FIFO entries, 2..64
IN_MARGIN, 2, free input slots still held when outStop asserts (covers sender retry latency); must be < IN_DEPTH
OUT_MARGIN, 2, free output slots still held when core_stop asserts (covers core pipeline drain); must be < OUT_DEPTH
IDLE_VAL, OUT_W'(0), value driven on outputInterface when outValid=0

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
inputInterface  in  IN_W  packet from switch
instValid  in  1  inputInterface valid this cycle
outStop  out  1  retry to switch
core_inst  out  IN_W  head of input FIFO to core
core_instValid  out  1  core_inst valid; core consumes it the same cycle
core_stop  out  1  stall to core
core_out  in  OUT_W  packet from core
core_outValid  in  1  core_out valid
outputInterface  out  OUT_W  packet to switch
outValid  out  1  outputInterface valid
stop  in  1  downstream stop
in_level  out  $clog2(IN_DEPTH+1)  input FIFO occupancy
out_level  out  $clog2(OUT_DEPTH+1)  output FIFO occupancy
err  out  2  sticky: [0] input overflow drop, [1] output overflow drop

Behaviour:
- Reset values: FIFOs empty, pointers 0, levels 0, outStop=0, core_stop=0, core_instValid=0, outValid=0, outputInterface=IDLE_VAL, err=0. Reset asserted mid-operation discards all queued packets immediately.
- Input FIFO push: instValid=1. The push is not gated by outStop; the sender honours outStop within IN_MARGIN cycles.
- Input FIFO pop: core_instValid=1.
  - core_instValid = !in_empty && !core_stop (combinational).
  - core_inst = head entry, or 0 when the FIFO is empty.
- outStop is registered: next value = (in_level_next >= IN_DEPTH-IN_MARGIN). It deasserts one cycle after the level falls below the threshold.
- Output FIFO push: core_outValid=1. The push is accepted even while core_stop=1, because the core drains in-flight work.
- Output FIFO pop: outValid=1.
  - outValid = !out_empty && !stop (combinational).
  - outputInterface = head when outValid, else IDLE_VAL.
- core_stop is registered: next value = (out_level_next >= OUT_DEPTH-OUT_MARGIN).
- Simultaneous push and pop:
  - On a full FIFO, the pop frees the slot and the push is accepted; level is unchanged.
  - On an empty FIFO, no pop occurs (valid=0) and the push lands. Data takes 1 cycle minimum through each FIFO; there is no bypass.
- Overflow: push while full with no pop in the same cycle drops the packet, leaves the FIFO unchanged and sets the matching err bit. err clears only on reset.
- Pointers wrap explicitly at DEPTH-1 → 0, so non-power-of-two depths are legal.
- Latency:
  - switch → core: 1 cycle when the input FIFO was empty and core_stop=0.
  - core → switch: 1 cycle when the output FIFO was empty and stop=0.
- Ordering is strictly FIFO on both paths. The block never duplicates or reorders packets.

Decomposition:
- Package nova_inter_buf_pkg: level/pointer width functions, err bit index constants, and the default IN_W/OUT_W values derived from BitstreamType/RamDataType widths so they match InputPacketType/OutputPacketType.
- Sub-module nova_buf_fifo (WIDTH, DEPTH, MARGIN): storage, pointers, level, registered almost-full flag and overflow pulse. It is instantiated twice; the top level is only valid/stop glue plus the err register.

Test Plan:
- Reset then idle → all outputs at reset values; outputInterface=IDLE_VAL; in_level=0.
- Single packet 0xA5… with core_stop=0 → core_instValid=1 with core_inst=0xA5… exactly 1 cycle later; in_level returns to 0.
- Hold the core off by forcing out FIFO near-full, push 6 packets into IN_DEPTH=8, IN_MARGIN=2 → outStop rises the cycle after the 6th push. Push 2 more → no err. Push a 9th → err[0]=1 and the packet is dropped; draining yields exactly the first 8 in order.
- stop=1 while core emits 4 packets (OUT_DEPTH=4, OUT_MARGIN=2) → core_stop=1 after the 2nd, all 4 stored, outValid=0. Release stop → 4 packets out on consecutive cycles in order, then outValid=0 and IDLE_VAL.
- Full FIFO with simultaneous push+pop every cycle for 20 cycles → level stays 8, no err, sequence intact.
- Assert reset_n=0 asynchronously with both FIFOs half full → levels 0 and valids 0 immediately (before the next clk edge); after release, new traffic flows with no stale packets.

Source files
------------

// File: rtl/nova_inter_buf_pkg.sv
// Shared widths, error-bit positions and sizing helpers for the nova switch/core buffer.
package nova_inter_buf_pkg;

  localparam int BITSTREAM_W = 32;
  localparam int RAM_DATA_W  = 32;

  // The input packet is one bitstream word plus two RAM data words. The output packet is four RAM data words.
  localparam int IN_W_DEF  = BITSTREAM_W + 2 * RAM_DATA_W;
  localparam int OUT_W_DEF = 4 * RAM_DATA_W;

  localparam int ERR_IN_OVF  = 0;
  localparam int ERR_OUT_OVF = 1;

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/nova_inter_buf_if.sv
// Switch-side and core-side signals of the nova buffer, bundled so that they can be passed as one port.
interface nova_inter_buf_if #(
  parameter int IN_W  = nova_inter_buf_pkg::IN_W_DEF,
  parameter int OUT_W = nova_inter_buf_pkg::OUT_W_DEF
);
  // Handshake semantics:
  // - A valid signal transfers its data in the cycle in which it is high. There is no separate ready signal.
  // - outStop and core_stop are registered back-pressure hints. The buffer keeps margin slots so that
  //   senders can react late.
  // - stop gates outValid combinationally, so a word is only presented when it is also taken.
  logic [IN_W-1:0]  inputInterface;
  logic             instValid;
  logic             outStop;
  logic [IN_W-1:0]  core_inst;
  logic             core_instValid;
  logic             core_stop;
  logic [OUT_W-1:0] core_out;
  logic             core_outValid;
  logic [OUT_W-1:0] outputInterface;
  logic             outValid;
  logic             stop;

  modport slave (
    input  inputInterface, instValid, core_out, core_outValid, stop,
    output outStop, core_inst, core_instValid, core_stop, outputInterface, outValid
  );

  modport master (
    output inputInterface, instValid, core_out, core_outValid, stop,
    input  outStop, core_inst, core_instValid, core_stop, outputInterface, outValid
  );
endinterface

// File: rtl/nova_buf_fifo.sv
// Elastic FIFO with explicit pointer wrap, an occupancy level, a registered almost-full flag and an overflow pulse.
module nova_buf_fifo
  import nova_inter_buf_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int MARGIN = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       empty_o,
  output logic [lvl_w(DEPTH)-1:0]    level_o,
  output logic                       afull_o,
  output logic                       ovf_o
);
  localparam int LW = lvl_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic             afull_q, afull_d;
  logic             full, do_push, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (lvl_q == '0);
  assign full    = (lvl_q == LW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i && (!full || do_pop);
  assign ovf_o   = push_i && full && !do_pop;

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    lvl_d   = lvl_q + LW'(do_push) - LW'(do_pop);
    if (do_push) wr_d = inc(wr_q);
    if (do_pop)  rd_d = inc(rd_q);
    afull_d = (lvl_d >= LW'(DEPTH - MARGIN));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      wr_q    <= '0;
      lvl_q   <= '0;
      afull_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      lvl_q   <= lvl_d;
      afull_q <= afull_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign head_o  = empty_o ? '0 : mem_q[rd_q];
  assign level_o = lvl_q;
  assign afull_o = afull_q;

endmodule

// File: rtl/nova_inter_buf.sv
// Switch <-> nova core wrapper: one elastic FIFO per direction, occupancy-based retry and sticky overflow flags.
module nova_inter_buf
  import nova_inter_buf_pkg::*;
#(
  parameter int             IN_W       = IN_W_DEF,
  parameter int             OUT_W      = OUT_W_DEF,
  parameter int             IN_DEPTH   = 8,
  parameter int             OUT_DEPTH  = 4,
  parameter int             IN_MARGIN  = 2,
  parameter int             OUT_MARGIN = 2,
  parameter logic [OUT_W-1:0] IDLE_VAL = '0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  nova_inter_buf_if.slave               bus,
  output logic [lvl_w(IN_DEPTH)-1:0]    in_level,
  output logic [lvl_w(OUT_DEPTH)-1:0]   out_level,
  output logic [1:0]                    err
);
  logic             in_empty, in_ovf;
  logic             out_empty, out_ovf;
  logic [OUT_W-1:0] out_head;
  logic [1:0]       err_q, err_d;

  // The core takes core_inst in the same cycle. It is held back only by the output side filling up.
  assign bus.core_instValid = !in_empty && !bus.core_stop;

  nova_buf_fifo #(.WIDTH(IN_W), .DEPTH(IN_DEPTH), .MARGIN(IN_MARGIN)) u_in_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (bus.instValid),
    .data_i  (bus.inputInterface),
    .pop_i   (bus.core_instValid),
    .head_o  (bus.core_inst),
    .empty_o (in_empty),
    .level_o (in_level),
    .afull_o (bus.outStop),
    .ovf_o   (in_ovf)
  );

  assign bus.outValid        = !out_empty && !bus.stop;
  assign bus.outputInterface = bus.outValid ? out_head : IDLE_VAL;

  // Core output is accepted even while core_stop is high. The margin absorbs the in-flight words.
  nova_buf_fifo #(.WIDTH(OUT_W), .DEPTH(OUT_DEPTH), .MARGIN(OUT_MARGIN)) u_out_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (bus.core_outValid),
    .data_i  (bus.core_out),
    .pop_i   (bus.outValid),
    .head_o  (out_head),
    .empty_o (out_empty),
    .level_o (out_level),
    .afull_o (bus.core_stop),
    .ovf_o   (out_ovf)
  );

  always_comb begin
    err_d = err_q;
    if (in_ovf)  err_d[ERR_IN_OVF]  = 1'b1;
    if (out_ovf) err_d[ERR_OUT_OVF] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= '0;
    else          err_q <= err_d;
  end

  assign err = err_q;

endmodule
